conv_serial_driver: RTL
=======================

// Module: conv_serial_driver
// PURPOSE
//  Transmit end of the serial 3x3 convolution interface: streams a stored 7x7 IFM and 3x3 kernel to the conv core.
//  Collects the core's 25 serial OFM results into a result buffer the host can read back.
//  Sits between the host/testbench config port and the conv core; also serves as the on-chip pattern source.
// PARAMETERS
//  DATA_W   16   IFM / weight word width
//  OUT_W    25   OFM result width
//  IFM_N    49   IFM words per frame (7x7)
//  W_N      9    weight words per kernel (3x3)
//  OFM_N    25   OFM words per frame (5x5)
//  TIMEOUT  256  max idle cycles in WAIT/RECV before abort
// PORTS
//  clk           in   1       clock, all logic on posedge
//  rst_n         in   1       synchronous reset, ACTIVE-HIGH (asserted = 1); port name kept per codebase naming
//  cfg_we        in   1       host write strobe
//  cfg_sel       in   1       0 = IFM memory, 1 = weight memory
//  cfg_addr      in   6       write address
//  cfg_wdata     in   DATA_W  write data
//  start         in   1       1-cycle pulse: begin one frame transaction
//  busy          out  1       high from cycle after accepted start until DONE exits
//  done          out  1       1-cycle pulse: 25 results captured
//  timeout_err   out  1       sticky abort flag; cleared by next accepted start
//  in_valid      out  1       IFM beat valid to core
//  weight_valid  out  1       weight beat valid to core
//  In_IFM_1      out  DATA_W  IFM word to core
//  In_Weight_1   out  DATA_W  weight word to core
//  out_valid     in   1       OFM beat valid from core
//  Out_OFM       in   OUT_W   OFM word from core
//  res_addr      in   5       result read address
//  res_rdata     out  OUT_W   result word, registered, 1-cycle read latency
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. IFM/weight/result memories are NOT cleared.
//  States:
//   - IDLE -> SEND on start.
//   - SEND -> WAIT after beat IFM_N-1.
//   - WAIT -> RECV on first out_valid.
//   - RECV -> DONE after OFM_N accepted beats.
//   - DONE -> IDLE (one cycle; done=1).
//   - WAIT/RECV -> IDLE on timeout.
//  SEND: start seen at cycle t -> in_valid=1 cycles t+1..t+49, In_IFM_1=ifm[k] on beat k.
//   weight_valid=1 on beats 0..8 only, concurrent with in_valid, In_Weight_1=w[k]; otherwise both valids 0 and data 0.
//  All core-facing outputs registered; no gaps in SEND; in_valid deasserts exactly after beat 48.
//  WAIT/RECV: each out_valid beat writes Out_OFM to res[j], j=0..24; gaps between beats allowed.
//   Idle counter resets on each beat; reaching TIMEOUT sets timeout_err=1, busy=0, no done, back to IDLE.
//  out_valid outside WAIT/RECV ignored; beats beyond 25 never occur in state (DONE entered at 25th).
//  start while busy ignored. cfg_we while busy ignored.
//  cfg_addr >= IFM_N (sel 0) or >= W_N (sel 1) ignored.
//  res_rdata reads res[res_addr] any time; res_addr >= 25 returns 0.
//  Reset asserted mid-SEND: in_valid/weight_valid drop to 0 the following edge; transaction discarded.
// STRUCTURE
//  Shared package conv_pkg:
//   - IFM_N/W_N/OFM_N/DATA_W/OUT_W constants.
//   - drv_state_t enum {IDLE, SEND, WAIT, RECV, DONE}.
//  One sub-module: conv_buf_1w1r (parameterised depth/width, 1 write port, registered read), instanced 3x for IFM, weight, result.
//  FSM, beat counter (6b), result index (5b), timeout counter in top.
// TESTING
//  1. Load ifm[k]=k+1, w[k]=1, start -> 49 in_valid beats 1..49, weight_valid beats 0..8 data 1, then in_valid=0.
//  2. Core model returns 25 beats Out_OFM=100+j -> done pulse once; res_rdata(addr 24)=124, busy falls with done.
//  3. Core beats with 3-cycle gaps -> all 25 captured in order, no timeout_err.
//  4. No out_valid after SEND -> timeout_err=1 exactly TIMEOUT cycles after entering WAIT, done never pulses.
//  5. start and cfg_we (addr 0, data 0xFFFF) during SEND -> ignored; next frame still sends original ifm[0].
//  6. rst_n=1 at beat 20 of SEND -> next edge all outputs 0, state IDLE; re-start sends full 49-beat frame.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and state type for the conv serial driver
package conv_pkg;

    localparam int DATA_W  = 16;
    localparam int OUT_W   = 25;
    localparam int IFM_N   = 49;
    localparam int W_N     = 9;
    localparam int OFM_N   = 25;
    localparam int TIMEOUT = 256;

    // Counter widths: beat counter spans the IFM frame, result index spans the OFM frame
    localparam int BEAT_W  = 6;
    localparam int RES_W   = 5;
    localparam int TO_W    = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        RECV,
        DONE
    } drv_state_t;

endpackage

// File: rtl/conv_buf_1w1r.sv
// rtl/conv_buf_1w1r.sv - single write port, registered read port buffer
module conv_buf_1w1r #(
    parameter int DEPTH = 49,
    parameter int WIDTH = 16,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int             IW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_A = (AW+1)'(DEPTH);

    // Storage is deliberately left uninitialised: reset must not wipe loaded frames
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    logic wr_in_range;
    logic rd_in_range;

    assign wr_in_range = ({1'b0, waddr} < DEPTH_A);
    assign rd_in_range = ({1'b0, raddr} < DEPTH_A);

    // Write port: out-of-range addresses are dropped
    always_ff @(posedge clk) begin
        if (we && wr_in_range) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    // Registered read: out-of-range addresses read as zero, reset clears only the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_in_range) begin
            rdata_q <= mem[raddr[IW-1:0]];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/conv_serial_driver.sv
// rtl/conv_serial_driver.sv - streams IFM/kernel to the conv core and captures its OFM results
module conv_serial_driver
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [5:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic              in_valid,
    output logic              weight_valid,
    output logic [DATA_W-1:0] In_IFM_1,
    output logic [DATA_W-1:0] In_Weight_1,
    input  logic              out_valid,
    input  logic [OUT_W-1:0]  Out_OFM,
    input  logic [4:0]        res_addr,
    output logic [OUT_W-1:0]  res_rdata
);

    // rst_n is active-high despite its name
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(IFM_N - 1);
    localparam logic [BEAT_W-1:0] IFM_A     = BEAT_W'(IFM_N);
    localparam logic [BEAT_W-1:0] W_A       = BEAT_W'(W_N);
    localparam logic [RES_W-1:0]  RES_LAST  = RES_W'(OFM_N - 1);
    localparam logic [TO_W-1:0]   IDLE_LAST = TO_W'(TIMEOUT - 1);

    drv_state_t        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [RES_W-1:0]  res_idx_q, res_idx_d;
    logic [TO_W-1:0]   idle_q, idle_d;
    logic              timeout_err_q, timeout_err_d;

    logic              res_we;
    logic              ifm_we;
    logic              w_we;
    logic [BEAT_W-1:0] rd_addr;
    logic [DATA_W-1:0] ifm_rdata;
    logic [DATA_W-1:0] w_rdata;

    // Host writes land only while idle and only at addresses inside the target memory
    assign ifm_we = cfg_we && !busy && !cfg_sel && (cfg_addr < IFM_A);
    assign w_we   = cfg_we && !busy &&  cfg_sel && (cfg_addr < W_A);

    // Memories read one beat ahead so their registered output lines up with the current beat
    assign rd_addr = (state_q == SEND) ? (beat_q + BEAT_W'(1)) : '0;

    conv_buf_1w1r #(
        .DEPTH (IFM_N),
        .WIDTH (DATA_W),
        .AW    (BEAT_W)
    ) u_ifm_buf (
        .clk   (clk),
        .rst   (rst_n),
        .we    (ifm_we),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (rd_addr),
        .rdata (ifm_rdata)
    );

    conv_buf_1w1r #(
        .DEPTH (W_N),
        .WIDTH (DATA_W),
        .AW    (BEAT_W)
    ) u_w_buf (
        .clk   (clk),
        .rst   (rst_n),
        .we    (w_we),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (rd_addr),
        .rdata (w_rdata)
    );

    conv_buf_1w1r #(
        .DEPTH (OFM_N),
        .WIDTH (OUT_W),
        .AW    (RES_W)
    ) u_res_buf (
        .clk   (clk),
        .rst   (rst_n),
        .we    (res_we),
        .waddr (res_idx_q),
        .wdata (Out_OFM),
        .raddr (res_addr),
        .rdata (res_rdata)
    );

    // State, counters and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            res_idx_q     <= '0;
            idle_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            res_idx_q     <= res_idx_d;
            idle_q        <= idle_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state logic: send the frame, then collect results until done or idle too long
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        res_idx_d     = res_idx_q;
        idle_d        = idle_q;
        timeout_err_d = timeout_err_q;
        res_we        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = SEND;
                    beat_d        = '0;
                    res_idx_d     = '0;
                    idle_d        = '0;
                    timeout_err_d = 1'b0;
                end
            end
            SEND: begin
                if (beat_q == BEAT_LAST) begin
                    state_d = WAIT;
                    beat_d  = '0;
                    idle_d  = '0;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            WAIT, RECV: begin
                if (out_valid) begin
                    res_we = 1'b1;
                    idle_d = '0;
                    if (res_idx_q == RES_LAST) begin
                        state_d = DONE;
                    end else begin
                        res_idx_d = res_idx_q + RES_W'(1);
                        state_d   = RECV;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    idle_d = idle_q + TO_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Core-facing outputs decode registered state; data is forced to zero outside valid beats
    assign in_valid     = (state_q == SEND);
    assign weight_valid = in_valid && (beat_q < W_A);
    assign In_IFM_1     = in_valid     ? ifm_rdata : '0;
    assign In_Weight_1  = weight_valid ? w_rdata   : '0;

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign timeout_err = timeout_err_q;

endmodule
